// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general register file with write-through bypass
// and a per-register pending-write scoreboard. Register 0 reads as zero,
// is never written and is never marked pending.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic [NUM_WR-1:0]        wen,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int NREG  = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wrAddr [NUM_WR];
   logic [DATA_W-1:0] wrData [NUM_WR];

   logic [DATA_W-1:0] grf_q [NREG];
   logic [DATA_W-1:0] grf_d [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;
   logic [CNT_W-1:0]  pendCnt_q;
   logic [CNT_W-1:0]  pendCnt_d;

   for (genvar wi = 0; wi < NUM_WR; wi++) begin : g_wr
      assign wrAddr[wi] = waddr[wi*ADDR_W +: ADDR_W];
      assign wrData[wi] = wdata[wi*DATA_W +: DATA_W];
   end

   // Next storage and busy state: writes in ascending port order so the highest port wins; the scoreboard set is applied last so a new producer overrides a same-cycle clear.
   always_comb begin
      grf_d  = grf_q;
      busy_d = busy_q;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wen[i] && (wrAddr[i] != '0)) begin
            grf_d[wrAddr[i]]  = wrData[i];
            busy_d[wrAddr[i]] = 1'b0;
         end
      end
      if (sb_set && (sb_addr != '0)) begin
         busy_d[sb_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Population count of the post-update busy bits, registered so pend_cnt trails the causing edge by one.
   always_comb begin
      pendCnt_d = '0;
      for (int k = 0; k < NREG; k++) begin
         pendCnt_d = pendCnt_d + CNT_W'(busy_d[k]);
      end
   end

   // State registers; reset clears storage, the scoreboard and the pending count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grf_q     <= '{default: '0};
         busy_q    <= '0;
         pendCnt_q <= '0;
      end else begin
         grf_q     <= grf_d;
         busy_q    <= busy_d;
         pendCnt_q <= pendCnt_d;
      end
   end

   assign pend_cnt = pendCnt_q;

   for (genvar rj = 0; rj < NUM_RD; rj++) begin : g_rd
      logic [ADDR_W-1:0] rdAddr;
      logic              bypassHit;
      logic [DATA_W-1:0] rdWord;

      assign rdAddr = raddr[rj*ADDR_W +: ADDR_W];

      // Read mux: storage by default, overridden by any same-cycle write to this address (highest port last), forced to zero for register 0 and while reset is held.
      always_comb begin
         bypassHit = 1'b0;
         rdWord    = grf_q[rdAddr];
         for (int i = 0; i < NUM_WR; i++) begin
            if (wen[i] && (wrAddr[i] == rdAddr)) begin
               bypassHit = 1'b1;
               rdWord    = wrData[i];
            end
         end
         if (reset || (rdAddr == '0)) begin
            rdWord = '0;
         end
      end

      assign rdata[rj*DATA_W +: DATA_W] = rdWord;
      assign rbusy[rj] = ~reset & busy_q[rdAddr] & ~bypassHit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural model of regfile_mp.
module tb_regfile_mp;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NR   = 3;
   localparam int NW   = 2;
   localparam int NREG = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [NW-1:0]     wen;
   logic [NW*AW-1:0]  waddr;
   logic [NW*DW-1:0]  wdata;
   logic              sb_set;
   logic [AW-1:0]     sb_addr;
   logic [AW:0]       pend_cnt;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] modelGrf  [NREG];
   logic          modelBusy [NREG];

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        ss;
      logic [4:0]  sa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] er0;
      logic [31:0] er1;
      logic [31:0] er2;
      logic [2:0]  eb;
      logic [5:0]  ep;
   } vec_t;

   vec_t vecs [15];

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk      (clk),
      .reset    (reset),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   // Keeps the run bounded even if something stalls the stimulus.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic modelClear();
      for (int i = 0; i < NREG; i++) begin
         modelGrf[i]  = '0;
         modelBusy[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [4:0] a);
      if (reset || a == 5'd0) return 32'h0;
      if (wen[1] && waddr[9:5] == a) return wdata[63:32];
      if (wen[0] && waddr[4:0] == a) return wdata[31:0];
      return modelGrf[a];
   endfunction

   function automatic logic modelRbusy(input logic [4:0] a);
      logic written;
      written = (wen[0] && waddr[4:0] == a) || (wen[1] && waddr[9:5] == a);
      return !reset && modelBusy[a] && !written;
   endfunction

   function automatic int modelPend();
      int n = 0;
      for (int i = 0; i < NREG; i++) if (modelBusy[i]) n++;
      return n;
   endfunction

   task automatic applyStimulus(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic ss, input logic [4:0] sa,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
      wen     = w;
      waddr   = {wa1, wa0};
      wdata   = {wd1, wd0};
      sb_set  = ss;
      sb_addr = sa;
      raddr   = {ra2, ra1, ra0};
      #1;
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [2:0] eb, input logic [5:0] ep);
      checkValue({tag, " rdata0"}, rdata[31:0], e0);
      checkValue({tag, " rdata1"}, rdata[63:32], e1);
      checkValue({tag, " rdata2"}, rdata[95:64], e2);
      checkValue({tag, " rbusy"}, 32'(rbusy), 32'(eb));
      checkValue({tag, " pend_cnt"}, 32'(pend_cnt), 32'(ep));
   endtask

   task automatic checkModel(input string tag);
      logic [4:0] a;
      for (int j = 0; j < NR; j++) begin
         a = raddr[j*AW +: AW];
         checkValue($sformatf("%s rdata%0d", tag, j), rdata[j*DW +: DW], modelRead(a));
         checkValue($sformatf("%s rbusy%0d", tag, j), 32'(rbusy[j]), 32'(modelRbusy(a)));
      end
      checkValue({tag, " pend_cnt"}, 32'(pend_cnt), 32'(modelPend()));
   endtask

   // Advance one edge and apply the architectural effect of the sampled inputs to the model.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         if (wen[0] && waddr[4:0] != 5'd0) begin
            modelGrf[waddr[4:0]]  = wdata[31:0];
            modelBusy[waddr[4:0]] = 1'b0;
         end
         if (wen[1] && waddr[9:5] != 5'd0) begin
            modelGrf[waddr[9:5]]  = wdata[63:32];
            modelBusy[waddr[9:5]] = 1'b0;
         end
         if (sb_set && sb_addr != 5'd0) modelBusy[sb_addr] = 1'b1;
      end
      #1;
   endtask

   function automatic logic [4:0] pickAddr();
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      // Directed vectors: one cycle each, expectations checked before the edge.
      vecs[0]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 5'd7, 32'h0,        32'h0,        32'h0,        3'b000, 6'd0};
      vecs[1]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 5'd3, 32'hDEADBEEF, 32'h0,        32'h0,        3'b000, 6'd0};
      vecs[2]  = '{2'b01, 5'd0, 5'd0, 32'h00001234, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 6'd0};
      vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        3'b000, 6'd0};
      vecs[4]  = '{2'b11, 5'd7, 5'd7, 32'hAAAA0001, 32'hAAAA0002, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0, 32'hDEADBEEF, 32'hAAAA0002, 32'h0,        3'b000, 6'd0};
      vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 5'd7, 32'hAAAA0002, 32'hAAAA0002, 32'hAAAA0002, 3'b000, 6'd0};
      vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 6'd0};
      vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 5'd7, 32'h0,        32'h0,        32'hAAAA0002, 3'b011, 6'd1};
      vecs[8]  = '{2'b01, 5'd9, 5'd0, 32'h00000055, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 5'd0, 32'h00000055, 32'hAAAA0002, 32'h0,        3'b000, 6'd1};
      vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'h00000055, 32'h00000055, 32'h00000055, 3'b000, 6'd0};
      vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        3'b000, 6'd0};
      vecs[11] = '{2'b10, 5'd0, 5'd3, 32'h0,        32'h00000033, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 32'h00000033, 32'h00000033, 32'h00000033, 3'b000, 6'd1};
      vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 5'd0, 32'h00000033, 32'h00000033, 32'h0,        3'b011, 6'd1};
      vecs[13] = '{2'b01, 5'd3, 5'd0, 32'h00000044, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 32'h00000044, 32'h0,        32'h0,        3'b000, 6'd1};
      vecs[14] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 32'h00000044, 32'h0,        32'h0,        3'b000, 6'd0};

      reset = 1'b0;
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3);
      reset = 1'b1;
      modelClear();
      #1;
      checkOutput("reset-state", 32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int v = 0; v < 15; v++) begin
         applyStimulus(vecs[v].wen, vecs[v].wa0, vecs[v].wa1, vecs[v].wd0, vecs[v].wd1,
                       vecs[v].ss, vecs[v].sa, vecs[v].ra0, vecs[v].ra1, vecs[v].ra2);
         checkOutput($sformatf("vec%0d", v), vecs[v].er0, vecs[v].er1, vecs[v].er2, vecs[v].eb, vecs[v].ep);
         tick();
      end

      // Asynchronous reset between edges with a write and a set in flight.
      applyStimulus(2'b01, 5'd20, 5'd0, 32'hCAFEF00D, 32'h0, 1'b1, 5'd12, 5'd20, 5'd12, 5'd5);
      tick();
      applyStimulus(2'b01, 5'd21, 5'd0, 32'h12345678, 32'h0, 1'b1, 5'd13, 5'd12, 5'd20, 5'd0);
      checkOutput("pre-reset", 32'h0, 32'hCAFEF00D, 32'h0, 3'b001, 6'd1);
      raddr = {5'd5, 5'd21, 5'd12};
      #1;
      reset = 1'b1;
      modelClear();
      #1;
      checkOutput("async-reset", 32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
      tick();
      reset = 1'b0;
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd21, 5'd5);
      checkOutput("after-reset", 32'h0, 32'h0, 32'h0, 3'b000, 6'd0);
      tick();

      // Fill the scoreboard one register per cycle, then drain it with writes.
      for (int k = 1; k < NREG; k++) begin
         applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'(k), 5'(k), 5'(k - 1), 5'd0);
         checkModel($sformatf("fill%0d", k));
         tick();
      end
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd31, 5'd1);
      checkOutput("fill-full", 32'h0, 32'h0, 32'h0, 3'b110, 6'd31);
      tick();
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      checkOutput("set-zero", 32'h0, 32'h0, 32'h0, 3'b000, 6'd31);
      for (int k = 1; k < NREG; k += 2) begin
         applyStimulus(2'b11, 5'(k), 5'(k + 1), 32'(k * 3), 32'(k * 5), 1'b0, 5'd0, 5'(k), 5'(k + 1), 5'(k + 2));
         checkModel($sformatf("drain%0d", k));
         tick();
      end
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 5'd31);
      checkOutput("drained", 32'd3, 32'd5, 32'd93, 3'b000, 6'd0);
      tick();

      // Randomized traffic against the model, with one asynchronous reset mid-run.
      for (int n = 0; n < 500; n++) begin
         applyStimulus(2'($urandom_range(0, 3)), pickAddr(), pickAddr(), $urandom(), $urandom(),
                       1'($urandom_range(0, 1)), pickAddr(), pickAddr(), pickAddr(), pickAddr());
         if (n == 250) begin
            reset = 1'b1;
            modelClear();
            #1;
         end
         checkModel($sformatf("rand%0d", n));
         tick();
         reset = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
